stage_mem_stream_ctrl: RTL and testbench
========================================

// Module: stage_mem_stream_ctrl
// PURPOSE
//  Initiator side of the 32x64 stage data memory: drives the memory's enable/address/wr_data
//  pins and consumes rd_data. Wraps the memory as a FIFO: input stream (valid/ready) writes
//  sequential addresses; output stream (valid/ready) reads them back in order. The 1-cycle
//  memory read latency is absorbed by a 2-entry output buffer to give 1 word/cycle throughput.
// PARAMETERS
//  WIDTH   32  data word width (matches memory data width)
//  AW      6   memory address width; DEPTH = 2**AW = 64 words
// PORTS
//  clk           in   1      clock; all logic on rising edge
//  reset         in   1      synchronous, active-high reset
//  flush         in   1      synchronous clear of all state; same effect as reset
//  in_valid      in   1      input word valid
//  in_data       in   WIDTH  input word
//  in_ready      out  1      space available in memory
//  out_valid     out  1      output word valid
//  out_data      out  WIDTH  output word (oldest)
//  out_ready     in   1      downstream accepts out_data
//  mem_wr_en     out  1      memory write strobe
//  mem_wr_addr   out  AW     memory write address
//  mem_wr_data   out  WIDTH  memory write data
//  mem_rd_en     out  1      memory read strobe
//  mem_rd_addr   out  AW     memory read address
//  mem_rd_data   in   WIDTH  memory read data, valid the cycle after mem_rd_en
//  level         out  AW+1   words in memory (0..64), excludes buffered/in-flight words
// BEHAVIOUR
//  Reset/flush: wr_ptr=rd_ptr=0, level=0, rd_pending=0, buffer empty. Next cycle: out_valid=0,
//   in_ready=1, mem_wr_en=0, mem_rd_en=0, level=0. Any in-flight read data is discarded.
//  Write side, combinational:
//   - in_ready = (level != 64)
//   - mem_wr_en = in_valid & in_ready & ~flush
//   - mem_wr_addr = wr_ptr; mem_wr_data = in_data
//   - wr_ptr increments on write and wraps 63->0
//  Read issue, combinational:
//   - mem_rd_en = (level != 0) & (buf_cnt + rd_pending - pop < 2) & ~flush
//     (buf_cnt 0..2; pop = out_valid & out_ready)
//   - mem_rd_addr = rd_ptr; rd_ptr increments on read, wraps 63->0
//   - rd_pending <= mem_rd_en
//  Level: level <= level + wr - rd. Simultaneous write+read leaves level unchanged.
//   - Writes count only from the next cycle, so a read never targets the address being
//     written in the same cycle (no read-during-write hazard).
//  Buffer: 2-entry in-order register FIFO.
//   - When rd_pending=1, mem_rd_data is pushed this cycle.
//   - out_data = head entry; out_valid = (buf_cnt != 0). Push and pop in the same cycle are
//     both legal.
//   - Overflow is impossible by construction of mem_rd_en; the bench asserts buf_cnt <= 2.
//  Latency: input handshake in cycle 0 with FIFO empty gives mem_rd_en in cycle 1, data on
//   mem_rd_data in cycle 2, out_valid=1 in cycle 3.
//  Throughput: with out_ready held high, one word per cycle is sustained in steady state.
//  Capacity: 64 words in memory plus up to 2 in the buffer. in_ready depends only on level.
//  Handshake rules: out_data/out_valid hold stable while out_valid & ~out_ready.
//   in_ready does not depend on in_valid.
//  Flush/reset mid-transfer: takes effect at the edge and overrides the same-cycle write, read
//   and pop. Data returned the cycle after flush is dropped (rd_pending cleared).
// TESTING
//  1 Reset -> level=0, out_valid=0, in_ready=1; one write of 0xA5A5_0001 -> out_valid=1 in
//    cycle 3 with out_data=0xA5A5_0001.
//  2 Stream 200 words (0,1,2..) with out_ready=1 -> 200 outputs in order, 1/cycle after
//    3-cycle fill, mem addresses wrap 63->0 three times.
//  3 Hold out_ready=0, write 70 words -> in_ready drops after word 66 accepted (64 in memory
//    + 2 buffered), level=64; release -> words 0..65 in order.
//  4 At level=64 assert out_ready for one cycle with in_valid=1 -> pop + refill keeps order,
//    no word lost or duplicated.
//  5 Random in_valid/out_ready (10k cycles) -> scoreboard match, buf_cnt<=2,
//    out_data stable while stalled.
//  6 Flush with level=10, read pending, out_valid=1 -> next cycle out_valid=0, level=0;
//    next write 0x1234 is output first.

Source files
------------

// File: rtl/stage_mem_stream_ctrl.sv
// FIFO controller wrapping an external 1-cycle-latency stage memory.
// Sequential write/read pointers; a 2-entry output buffer hides the read latency.
module stage_mem_stream_ctrl #(
   parameter int WIDTH = 32,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             mem_wr_en,
   output logic [AW-1:0]    mem_wr_addr,
   output logic [WIDTH-1:0] mem_wr_data,
   output logic             mem_rd_en,
   output logic [AW-1:0]    mem_rd_addr,
   input  logic [WIDTH-1:0] mem_rd_data,
   output logic [AW:0]      level
);

   localparam logic [AW:0] LVL_FULL = {1'b1, {AW{1'b0}}};

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          r_rd_pending;
   logic [1:0]    r_buf_cnt;
   logic          r_head;

   logic             w_wr_en;
   logic             w_rd_en;
   logic             w_pop;
   logic             w_push;
   logic             w_tail;
   logic [2:0]       w_occ;
   logic [WIDTH-1:0] w_entry [2];

   assign w_wr_en = in_valid && in_ready && !flush;
   assign w_pop   = out_valid && out_ready;
   assign w_push  = r_rd_pending;

   // Words already buffered or on their way back, after this cycle's pop.
   assign w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_rd_pending} - {2'b00, w_pop};
   assign w_rd_en = (r_level != '0) && (w_occ < 3'd2) && !flush;

   // With two slots, the free slot is the head when full (only legal alongside a pop).
   assign w_tail  = r_head ^ r_buf_cnt[0];

   assign in_ready    = (r_level != LVL_FULL);
   assign mem_wr_en   = w_wr_en;
   assign mem_wr_addr = r_wr_ptr;
   assign mem_wr_data = in_data;
   assign mem_rd_en   = w_rd_en;
   assign mem_rd_addr = r_rd_ptr;
   assign level       = r_level;
   assign out_valid   = (r_buf_cnt != 2'd0);
   assign out_data    = w_entry[r_head];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
         r_rd_pending <= 1'b0;
         r_buf_cnt    <= 2'd0;
         r_head       <= 1'b0;
      end else begin
         r_wr_ptr     <= r_wr_ptr + AW'(w_wr_en);
         r_rd_ptr     <= r_rd_ptr + AW'(w_rd_en);
         r_level      <= r_level + (AW+1)'(w_wr_en) - (AW+1)'(w_rd_en);
         r_rd_pending <= w_rd_en;
         r_buf_cnt    <= r_buf_cnt + 2'(w_push) - 2'(w_pop);
         r_head       <= r_head ^ w_pop;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_buf
         logic [WIDTH-1:0] r_entry;
         always_ff @(posedge clk) begin
            if (w_push && !reset && !flush && (w_tail == 1'(gi)))
               r_entry <= mem_rd_data;
         end
         assign w_entry[gi] = r_entry;
      end
   endgenerate

endmodule

// File: tb/tb_stage_mem_stream_ctrl.sv
// Bench for stage_mem_stream_ctrl: behavioural memory, word-queue scoreboard,
// vector table for the first transfers, directed capacity/flush sequences, random traffic.
module tb_stage_mem_stream_ctrl;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] in_data;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic        mem_wr_en, mem_rd_en;
   logic [5:0]  mem_wr_addr, mem_rd_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data = 32'h0;
   logic [6:0]  level;

   always #5 clk = ~clk;

   stage_mem_stream_ctrl #(.WIDTH(32), .AW(6)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .level(level)
   );

   // 64x32 memory with registered read
   logic [31:0] mem [64];
   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Scoreboard: words accepted but not yet delivered, plus occupancy counts from the pins.
   logic [31:0] q [$];
   int mlevel = 0, wr_a = 0, rd_a = 0, inflight = 0;
   int pops = 0, wr_wraps = 0, rd_wraps = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = 32'h0;

   always @(negedge clk) begin
      logic acc, pop;
      logic [31:0] w;
      #4;
      if (reset || flush) begin
         if (!reset) begin
            check("flush_wr_en", mem_wr_en, 0);
            check("flush_rd_en", mem_rd_en, 0);
         end
         q.delete();
         mlevel = 0; wr_a = 0; rd_a = 0; inflight = 0; prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
         end
         check("level", level, mlevel);
         check("in_ready", in_ready, (mlevel != 64));
         acc = in_valid && in_ready;
         pop = out_valid && out_ready;
         check("wr_en", mem_wr_en, acc);
         if (out_valid && q.size() == 0)
            check("valid_when_empty", out_valid, 0);
         if (pop && q.size() != 0) begin
            w = q.pop_front();
            check("out_data", out_data, w);
            inflight--;
            pops++;
         end
         if (acc) begin
            check("wr_addr", mem_wr_addr, wr_a);
            check("wr_data", mem_wr_data, in_data);
            q.push_back(in_data);
            if (wr_a == 63) wr_wraps++;
            wr_a = (wr_a + 1) % 64;
         end
         if (mem_rd_en) begin
            check("rd_nonempty", (mlevel > 0), 1);
            check("rd_addr", mem_rd_addr, rd_a);
            if (rd_a == 63) rd_wraps++;
            rd_a = (rd_a + 1) % 64;
            inflight++;
         end
         check("inflight_le2", (inflight > 2), 0);
         mlevel = mlevel + (acc ? 1 : 0) - (mem_rd_en ? 1 : 0);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   typedef struct {
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic        e_ov;
      logic [31:0] e_od;
      logic        e_ir;
      logic [6:0]  e_lvl;
      logic        e_wr;
      logic        e_rd;
   } vec_t;

   vec_t tbl [12];

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int sent, got, first, last, acc_n, p0, w0, r0;
      logic a;

      tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0,         1'b1, 7'd0, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 7'd1, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 7'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 7'd0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_0001, 1'b1, 7'd0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 7'd0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 32'h0000_00B0, 1'b1, 1'b0, 32'h0,         1'b1, 7'd0, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 32'h0000_00B1, 1'b1, 1'b0, 32'h0,         1'b1, 7'd1, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 7'd1, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_00B0, 1'b1, 7'd0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_00B1, 1'b1, 7'd0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 7'd0, 1'b0, 1'b0};

      @(negedge clk);
      do_reset();
      #2;
      check("rst_level", level, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);

      // Vector table: single-word latency and a two-word burst
      for (int k = 0; k < 12; k++) begin
         in_valid = tbl[k].iv; in_data = tbl[k].id; out_ready = tbl[k].ordy;
         #2;
         check("vec_out_valid", out_valid, tbl[k].e_ov);
         if (tbl[k].e_ov) check("vec_out_data", out_data, tbl[k].e_od);
         check("vec_in_ready", in_ready, tbl[k].e_ir);
         check("vec_level", level, tbl[k].e_lvl);
         check("vec_wr_en", mem_wr_en, tbl[k].e_wr);
         check("vec_rd_en", mem_rd_en, tbl[k].e_rd);
         $display("vec %0d: out_valid=%0b out_data=%h level=%0d rd_en=%0b",
                  k, out_valid, out_data, level, mem_rd_en);
         @(negedge clk);
      end

      // 200-word stream at full rate
      do_reset();
      w0 = wr_wraps; r0 = rd_wraps;
      sent = 0; got = 0; first = -1; last = -1;
      out_ready = 1'b1;
      for (int t = 0; t < 400 && got < 200; t++) begin
         in_valid = (sent < 200); in_data = sent;
         #2;
         if (out_valid) begin
            if (first < 0) first = t;
            last = t;
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("stream_count", got, 200);
      check("stream_first_cycle", first, 3);
      check("stream_span", last - first, 199);
      check("stream_wr_wraps", wr_wraps - w0, 3);
      check("stream_rd_wraps", rd_wraps - r0, 3);
      $display("stream: %0d words, first at cycle %0d, last at cycle %0d", got, first, last);

      // Fill with output stalled
      do_reset();
      p0 = pops;
      sent = 0;
      for (int t = 0; t < 100; t++) begin
         in_valid = (sent < 70); in_data = sent;
         #2;
         if (in_valid && in_ready) sent++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2;
      check("full_accepted", sent, 66);
      check("full_level", level, 64);
      check("full_in_ready", in_ready, 0);
      check("full_out_valid", out_valid, 1);
      $display("fill: accepted %0d words, level=%0d", sent, level);

      // One pop at full level while a write waits
      in_valid = 1'b1; in_data = 32'd1000; out_ready = 1'b1;
      #2;
      check("full_pop_in_ready", in_ready, 0);
      check("full_pop_rd_en", mem_rd_en, 1);
      @(negedge clk);
      out_ready = 1'b0;
      acc_n = 0;
      for (int t = 0; t < 5; t++) begin
         #2;
         a = in_ready;
         @(negedge clk);
         if (a) begin
            acc_n++;
            in_valid = 1'b0;
            break;
         end
      end
      in_valid = 1'b0;
      #2;
      check("refill_accepts", acc_n, 1);
      check("refill_level", level, 64);
      out_ready = 1'b1;
      for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
      check("full_drain_empty", q.size(), 0);
      check("full_drain_pops", pops - p0, 67);
      $display("refill/drain: %0d words delivered", pops - p0);

      // Flush with level=10, a read pending and output valid
      do_reset();
      for (int t = 0; t < 13; t++) begin
         in_valid = 1'b1; in_data = 32'h5000 + t;
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      check("pre_flush_level", level, 11);
      out_ready = 1'b1;
      #1;
      check("pre_flush_rd_en", mem_rd_en, 1);
      @(negedge clk);
      out_ready = 1'b0;
      #2;
      check("flush_setup_level", level, 10);
      check("flush_setup_valid", out_valid, 1);
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #2;
      check("post_flush_valid", out_valid, 0);
      check("post_flush_level", level, 0);
      check("post_flush_in_ready", in_ready, 1);
      check("post_flush_rd_en", mem_rd_en, 0);
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h1234;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      got = 0;
      for (int t = 0; t < 10 && got == 0; t++) begin
         #2;
         if (out_valid) got = 1;
         else @(negedge clk);
      end
      check("post_flush_seen", got, 1);
      check("post_flush_data", out_data, 32'h1234);
      $display("flush: first word after flush = %h", out_data);
      @(negedge clk);

      // Random traffic in phases of balanced, stalled and draining consumers
      do_reset();
      p0 = pops;
      for (int t = 0; t < 10000; t++) begin
         int mode;
         mode = (t / 1000) % 3;
         in_valid = 1'($urandom_range(0, 1));
         in_data = $urandom;
         case (mode)
            0: out_ready = 1'($urandom_range(0, 1));
            1: out_ready = ($urandom_range(0, 7) == 0);
            default: out_ready = ($urandom_range(0, 7) != 0);
         endcase
         flush = ($urandom_range(0, 999) == 0);
         @(negedge clk);
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
      repeat (3) @(negedge clk);
      #2;
      check("rand_drain_empty", q.size(), 0);
      check("rand_drain_level", level, 0);
      check("rand_drain_valid", out_valid, 0);
      $display("random: %0d words delivered", pops - p0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
